// File: rtl/net_arbiter_multi_if.sv
// Bundle of everything that crosses the arbiter boundary: the ownership request
// channel, NUM_DOM domain-side AXIS pairs, the shared NIC AXIS pair and the
// NIC reset / ownership status. The arbiter uses the slave view.
interface net_arbiter_multi_if #(
  parameter int NUM_DOM = 2,
  parameter int DW      = 32
);
  localparam int OW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int KW = DW / 8;

  // Ownership request channel
  logic                  req_valid;
  logic [OW-1:0]         req_owner;
  logic                  req_ready;

  // Domain-side tx streams (domain -> arbiter)
  logic [NUM_DOM*DW-1:0] D_txd_tdata;
  logic [NUM_DOM*KW-1:0] D_txd_tkeep;
  logic [NUM_DOM-1:0]    D_txd_tlast;
  logic [NUM_DOM-1:0]    D_txd_tvalid;
  logic [NUM_DOM-1:0]    D_txd_tready;

  // Domain-side rx streams (arbiter -> domain)
  logic [NUM_DOM*DW-1:0] D_rxd_tdata;
  logic [NUM_DOM*KW-1:0] D_rxd_tkeep;
  logic [NUM_DOM-1:0]    D_rxd_tlast;
  logic [NUM_DOM-1:0]    D_rxd_tvalid;
  logic [NUM_DOM-1:0]    D_rxd_tready;

  // NIC tx stream (arbiter -> NIC)
  logic [DW-1:0]         O_txd_tdata;
  logic [KW-1:0]         O_txd_tkeep;
  logic                  O_txd_tlast;
  logic                  O_txd_tvalid;
  logic                  O_txd_tready;

  // NIC rx stream (NIC -> arbiter)
  logic [DW-1:0]         O_rxd_tdata;
  logic [KW-1:0]         O_rxd_tkeep;
  logic                  O_rxd_tlast;
  logic                  O_rxd_tvalid;
  logic                  O_rxd_tready;

  // NIC reset and ownership status
  logic                  O_aresetn;
  logic [OW-1:0]         owner;
  logic                  owner_vld;
  logic                  trusted;
  logic                  forced_sw;

  modport slave (
    input  req_valid, req_owner,
    input  D_txd_tdata, D_txd_tkeep, D_txd_tlast, D_txd_tvalid,
    output D_txd_tready,
    output D_rxd_tdata, D_rxd_tkeep, D_rxd_tlast, D_rxd_tvalid,
    input  D_rxd_tready,
    output O_txd_tdata, O_txd_tkeep, O_txd_tlast, O_txd_tvalid,
    input  O_txd_tready,
    input  O_rxd_tdata, O_rxd_tkeep, O_rxd_tlast, O_rxd_tvalid,
    output O_rxd_tready,
    output req_ready, O_aresetn, owner, owner_vld, trusted, forced_sw
  );

  modport master (
    output req_valid, req_owner,
    output D_txd_tdata, D_txd_tkeep, D_txd_tlast, D_txd_tvalid,
    input  D_txd_tready,
    input  D_rxd_tdata, D_rxd_tkeep, D_rxd_tlast, D_rxd_tvalid,
    output D_rxd_tready,
    input  O_txd_tdata, O_txd_tkeep, O_txd_tlast, O_txd_tvalid,
    output O_txd_tready,
    output O_rxd_tdata, O_rxd_tkeep, O_rxd_tlast, O_rxd_tvalid,
    input  O_rxd_tready,
    input  req_ready, O_aresetn, owner, owner_vld, trusted, forced_sw
  );
endinterface

// File: rtl/net_arbiter_multi.sv
// N-domain NIC arbiter. One owner domain at a time gets a zero-latency AXIS
// path to the shared NIC. Ownership only moves at packet boundaries (or after
// a bounded drain), and every move is followed by a NIC reset pulse so no
// state leaks from one domain to the next. trusted/owner_vld are registered
// and only asserted in GRANTED, so they can never straddle an owner change.
module net_arbiter_multi #(
  parameter int NUM_DOM    = 2,
  parameter int DW         = 32,
  parameter int TRUSTED_ID = 0,
  parameter int DRAIN_TO   = 1024,
  parameter int RST_CYC    = 4
) (
  input  logic                  S_CLK,
  input  logic                  S_ARESETN,
  net_arbiter_multi_if.slave    bus
);
  localparam int OW   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int KW   = DW / 8;
  localparam int CMAX = (DRAIN_TO > RST_CYC) ? DRAIN_TO : RST_CYC;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [OW-1:0] TID        = OW'(TRUSTED_ID);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TO - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_NICRST  = 2'd3
  } state_t;

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   pending_q;
  logic [CW-1:0]   cnt_q;
  logic            owner_vld_q;
  logic            trusted_q;
  logic            forced_sw_q;
  logic            aresetn_q;
  logic            req_ready_q;
  logic            tx_inpkt_q;
  logic            rx_inpkt_q;
  logic            tx_inpkt_d;
  logic            rx_inpkt_d;

  logic                  tx_pass_s;
  logic                  rx_pass_s;
  logic [NUM_DOM-1:0]    tx_sel_s;
  logic [NUM_DOM-1:0]    rx_sel_s;
  logic                  req_ok_s;
  logic                  req_acc_s;
  logic                  tx_acc_s;
  logic                  rx_acc_s;

  logic [DW-1:0]         o_txd_tdata_s;
  logic [KW-1:0]         o_txd_tkeep_s;
  logic                  o_txd_tlast_s;
  logic                  o_txd_tvalid_s;
  logic                  o_rxd_tready_s;
  logic [NUM_DOM-1:0]    d_txd_tready_s;
  logic [NUM_DOM*DW-1:0] d_rxd_tdata_s;
  logic [NUM_DOM*KW-1:0] d_rxd_tkeep_s;
  logic [NUM_DOM-1:0]    d_rxd_tlast_s;
  logic [NUM_DOM-1:0]    d_rxd_tvalid_s;

  // Owner-selected AND-OR stream mux, request qualification and packet tracker next state
  always_comb begin
    tx_pass_s      = (state_q == ST_GRANTED) || ((state_q == ST_DRAIN) && tx_inpkt_q);
    rx_pass_s      = (state_q == ST_GRANTED) || ((state_q == ST_DRAIN) && rx_inpkt_q);
    tx_sel_s       = '0;
    rx_sel_s       = '0;
    o_txd_tdata_s  = '0;
    o_txd_tkeep_s  = '0;
    o_txd_tlast_s  = 1'b0;
    o_txd_tvalid_s = 1'b0;
    o_rxd_tready_s = 1'b0;
    d_txd_tready_s = '0;
    d_rxd_tdata_s  = '0;
    d_rxd_tkeep_s  = '0;
    d_rxd_tlast_s  = '0;
    d_rxd_tvalid_s = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      tx_sel_s[i]     = tx_pass_s && (owner_q == OW'(i));
      rx_sel_s[i]     = rx_pass_s && (owner_q == OW'(i));
      o_txd_tdata_s   = o_txd_tdata_s | (bus.D_txd_tdata[i*DW +: DW] & {DW{tx_sel_s[i]}});
      o_txd_tkeep_s   = o_txd_tkeep_s | (bus.D_txd_tkeep[i*KW +: KW] & {KW{tx_sel_s[i]}});
      o_txd_tlast_s   = o_txd_tlast_s  | (bus.D_txd_tlast[i]  & tx_sel_s[i]);
      o_txd_tvalid_s  = o_txd_tvalid_s | (bus.D_txd_tvalid[i] & tx_sel_s[i]);
      d_txd_tready_s[i] = bus.O_txd_tready & tx_sel_s[i];
      d_rxd_tdata_s[i*DW +: DW] = bus.O_rxd_tdata & {DW{rx_sel_s[i]}};
      d_rxd_tkeep_s[i*KW +: KW] = bus.O_rxd_tkeep & {KW{rx_sel_s[i]}};
      d_rxd_tlast_s[i]  = bus.O_rxd_tlast  & rx_sel_s[i];
      d_rxd_tvalid_s[i] = bus.O_rxd_tvalid & rx_sel_s[i];
      o_rxd_tready_s    = o_rxd_tready_s | (bus.D_rxd_tready[i] & rx_sel_s[i]);
    end
    // Out-of-range owners are dropped here so they can never reach the mux
    req_ok_s   = (int'({1'b0, bus.req_owner}) < NUM_DOM);
    req_acc_s  = bus.req_valid && req_ready_q && req_ok_s;
    tx_acc_s   = o_txd_tvalid_s && bus.O_txd_tready;
    rx_acc_s   = bus.O_rxd_tvalid && o_rxd_tready_s;
    tx_inpkt_d = (state_q == ST_NICRST) ? 1'b0 : (tx_acc_s ? !o_txd_tlast_s : tx_inpkt_q);
    rx_inpkt_d = (state_q == ST_NICRST) ? 1'b0 : (rx_acc_s ? !bus.O_rxd_tlast : rx_inpkt_q);
  end

  // Ownership FSM with registered status outputs, shared drain/reset counter and packet trackers
  always_ff @(posedge S_CLK) begin
    if (!S_ARESETN) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      owner_vld_q <= 1'b0;
      trusted_q   <= 1'b0;
      forced_sw_q <= 1'b0;
      aresetn_q   <= 1'b0;
      req_ready_q <= 1'b0;
      tx_inpkt_q  <= 1'b0;
      rx_inpkt_q  <= 1'b0;
    end else begin
      forced_sw_q <= 1'b0;
      tx_inpkt_q  <= tx_inpkt_d;
      rx_inpkt_q  <= rx_inpkt_d;
      case (state_q)
        ST_IDLE: begin
          aresetn_q   <= 1'b1;
          req_ready_q <= 1'b1;
          if (req_acc_s) begin
            state_q     <= ST_NICRST;
            pending_q   <= bus.req_owner;
            cnt_q       <= '0;
            aresetn_q   <= 1'b0;
            req_ready_q <= 1'b0;
          end
        end
        ST_GRANTED: begin
          if (req_acc_s && (bus.req_owner != owner_q)) begin
            state_q     <= ST_DRAIN;
            pending_q   <= bus.req_owner;
            cnt_q       <= '0;
            owner_vld_q <= 1'b0;
            trusted_q   <= 1'b0;
            req_ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!tx_inpkt_q && !rx_inpkt_q) begin
            state_q   <= ST_NICRST;
            cnt_q     <= '0;
            aresetn_q <= 1'b0;
          end else if (cnt_q == DRAIN_LAST) begin
            // Stalled packet: abandon it rather than hold the NIC forever
            state_q     <= ST_NICRST;
            cnt_q       <= '0;
            aresetn_q   <= 1'b0;
            forced_sw_q <= 1'b1;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_NICRST: begin
          if (cnt_q == RST_LAST) begin
            state_q     <= ST_GRANTED;
            owner_q     <= pending_q;
            owner_vld_q <= 1'b1;
            trusted_q   <= (pending_q == TID);
            aresetn_q   <= 1'b1;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          owner_vld_q <= 1'b0;
          trusted_q   <= 1'b0;
          aresetn_q   <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_txd_tdata  = o_txd_tdata_s;
  assign bus.O_txd_tkeep  = o_txd_tkeep_s;
  assign bus.O_txd_tlast  = o_txd_tlast_s;
  assign bus.O_txd_tvalid = o_txd_tvalid_s;
  assign bus.O_rxd_tready = o_rxd_tready_s;
  assign bus.D_txd_tready = d_txd_tready_s;
  assign bus.D_rxd_tdata  = d_rxd_tdata_s;
  assign bus.D_rxd_tkeep  = d_rxd_tkeep_s;
  assign bus.D_rxd_tlast  = d_rxd_tlast_s;
  assign bus.D_rxd_tvalid = d_rxd_tvalid_s;
  assign bus.req_ready    = req_ready_q;
  assign bus.O_aresetn    = aresetn_q;
  assign bus.owner        = owner_q;
  assign bus.owner_vld    = owner_vld_q;
  assign bus.trusted      = trusted_q;
  assign bus.forced_sw    = forced_sw_q;

endmodule

// File: tb/tb_net_arbiter_multi.sv
// Directed bench for net_arbiter_multi with three domains so that an
// out-of-range owner index (3) can be expressed on the 2-bit request port.
module tb_net_arbiter_multi;
  localparam int ND = 3;
  localparam int DW = 32;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_miss;
  int   n_wait;

  net_arbiter_multi_if #(.NUM_DOM(ND), .DW(DW)) bus ();

  net_arbiter_multi #(
    .NUM_DOM(ND), .DW(DW), .TRUSTED_ID(0), .DRAIN_TO(1024), .RST_CYC(4)
  ) dut (
    .S_CLK     (clk),
    .S_ARESETN (rstn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_tx(input int d, input logic [31:0] data, input logic last, input logic vld);
    bus.D_txd_tdata[d*DW +: DW] = data;
    bus.D_txd_tkeep[d*4 +: 4]   = 4'hF;
    bus.D_txd_tlast[d]          = last;
    bus.D_txd_tvalid[d]         = vld;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rstn = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_owner    = 2'd0;
    bus.D_txd_tdata  = '0;
    bus.D_txd_tkeep  = '0;
    bus.D_txd_tlast  = '0;
    bus.D_txd_tvalid = 3'b111;
    bus.D_rxd_tready = 3'b111;
    bus.O_txd_tready = 1'b1;
    bus.O_rxd_tdata  = 32'h0;
    bus.O_rxd_tkeep  = 4'h0;
    bus.O_rxd_tlast  = 1'b0;
    bus.O_rxd_tvalid = 1'b1;

    // 1: reset held three cycles blocks everything
    step(); step(); step();
    check_vec("rst_o_tvalid", 128'(bus.O_txd_tvalid), 128'(1'b0));
    check_vec("rst_d_tready", 128'(bus.D_txd_tready), 128'(3'b000));
    check_vec("rst_d_rvalid", 128'(bus.D_rxd_tvalid), 128'(3'b000));
    check_vec("rst_o_rready", 128'(bus.O_rxd_tready), 128'(1'b0));
    check_vec("rst_trusted",  128'(bus.trusted),      128'(1'b0));
    check_vec("rst_aresetn",  128'(bus.O_aresetn),    128'(1'b0));
    bus.D_txd_tvalid = 3'b000;
    bus.O_rxd_tvalid = 1'b0;
    rstn = 1'b1;
    step();
    check_vec("idle_aresetn",  128'(bus.O_aresetn), 128'(1'b1));
    check_vec("idle_reqrdy",   128'(bus.req_ready), 128'(1'b1));
    check_vec("idle_ownvld",   128'(bus.owner_vld), 128'(1'b0));

    // 2: grant domain 0, NIC reset exactly four cycles
    bus.req_valid = 1'b1;
    bus.req_owner = 2'd0;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_vec("grant_nicrst_low", 128'(bus.O_aresetn), 128'(1'b0));
      if (k < 3) step();
    end
    step();
    check_vec("grant_aresetn", 128'(bus.O_aresetn), 128'(1'b1));
    check_vec("grant_ownvld",  128'(bus.owner_vld), 128'(1'b1));
    check_vec("grant_trusted", 128'(bus.trusted),   128'(1'b1));
    check_vec("grant_owner",   128'(bus.owner),     128'(2'd0));
    drive_tx(0, 32'hA5A5_A5A5, 1'b0, 1'b1);
    #1;
    check_vec("grant_o_tdata", 128'(bus.O_txd_tdata),  128'(32'hA5A5_A5A5));
    check_vec("grant_o_tvld",  128'(bus.O_txd_tvalid), 128'(1'b1));
    check_vec("grant_d_trdy",  128'(bus.D_txd_tready), 128'(3'b001));

    // 3: clean switch to domain 1 in the middle of a 3-beat D0 packet
    step();
    drive_tx(0, 32'h0000_0002, 1'b0, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_owner = 2'd1;
    #1;
    check_vec("sw_beat2", 128'(bus.O_txd_tdata), 128'(32'h0000_0002));
    step();
    bus.req_valid = 1'b0;
    check_vec("sw_trusted_drop", 128'(bus.trusted),   128'(1'b0));
    check_vec("sw_ownvld_drop",  128'(bus.owner_vld), 128'(1'b0));
    check_vec("sw_reqrdy_drain", 128'(bus.req_ready), 128'(1'b0));
    drive_tx(0, 32'h0000_0003, 1'b1, 1'b1);
    #1;
    check_vec("sw_beat3_data", 128'(bus.O_txd_tdata),  128'(32'h0000_0003));
    check_vec("sw_beat3_trdy", 128'(bus.D_txd_tready), 128'(3'b001));
    step();
    drive_tx(0, 32'hDEAD_0000, 1'b0, 1'b1);
    #1;
    check_vec("sw_newpkt_blk",  128'(bus.D_txd_tready), 128'(3'b000));
    check_vec("sw_newpkt_ovld", 128'(bus.O_txd_tvalid), 128'(1'b0));
    step();
    check_vec("sw_nicrst", 128'(bus.O_aresetn), 128'(1'b0));
    step(); step(); step();
    check_vec("sw_nicrst_last", 128'(bus.O_aresetn), 128'(1'b0));
    step();
    check_vec("sw_owner1",   128'(bus.owner),     128'(2'd1));
    check_vec("sw_ownvld1",  128'(bus.owner_vld), 128'(1'b1));
    check_vec("sw_trusted1", 128'(bus.trusted),   128'(1'b0));
    check_vec("sw_aresetn1", 128'(bus.O_aresetn), 128'(1'b1));

    // 5: isolation while domain 1 owns the NIC
    #1;
    check_vec("iso_d_trdy", 128'(bus.D_txd_tready), 128'(3'b010));
    check_vec("iso_o_tvld", 128'(bus.O_txd_tvalid), 128'(1'b0));
    check_vec("iso_o_tdat", 128'(bus.O_txd_tdata),  128'(32'h0));
    bus.O_rxd_tdata  = 32'h1234_5678;
    bus.O_rxd_tkeep  = 4'hF;
    bus.O_rxd_tlast  = 1'b1;
    bus.O_rxd_tvalid = 1'b1;
    drive_tx(1, 32'hBEEF_0001, 1'b1, 1'b1);
    #1;
    check_vec("iso_d_rvld", 128'(bus.D_rxd_tvalid), 128'(3'b010));
    check_vec("iso_d_rdat", 128'(bus.D_rxd_tdata),  128'({32'h0, 32'h1234_5678, 32'h0}));
    check_vec("iso_o_rrdy", 128'(bus.O_rxd_tready), 128'(1'b1));
    check_vec("iso_d1_tx",  128'(bus.O_txd_tdata),  128'(32'hBEEF_0001));
    bus.O_rxd_tvalid = 1'b0;
    bus.D_txd_tvalid = 3'b000;

    // 6: out-of-range and duplicate requests are no-ops
    bus.req_valid = 1'b1;
    bus.req_owner = 2'd3;
    step();
    check_vec("bad_ownvld",  128'(bus.owner_vld), 128'(1'b1));
    check_vec("bad_owner",   128'(bus.owner),     128'(2'd1));
    check_vec("bad_reqrdy",  128'(bus.req_ready), 128'(1'b1));
    bus.req_owner = 2'd1;
    step();
    bus.req_valid = 1'b0;
    step(); step();
    check_vec("dup_aresetn", 128'(bus.O_aresetn), 128'(1'b1));
    check_vec("dup_ownvld",  128'(bus.owner_vld), 128'(1'b1));
    check_vec("dup_trusted", 128'(bus.trusted),   128'(1'b0));

    // 4: owner stalls mid-packet, drain times out and forces the switch
    drive_tx(1, 32'h0000_00A1, 1'b0, 1'b1);
    step();
    bus.D_txd_tvalid = 3'b000;
    bus.req_valid = 1'b1;
    bus.req_owner = 2'd0;
    step();
    bus.req_valid = 1'b0;
    n_wait = 0;
    while (bus.forced_sw !== 1'b1 && n_wait < 2000) begin
      step();
      n_wait = n_wait + 1;
    end
    check_vec("to_wait_cycles", 128'(n_wait),        128'(1024));
    check_vec("to_aresetn",     128'(bus.O_aresetn), 128'(1'b0));
    step();
    check_vec("to_forced_pulse", 128'(bus.forced_sw), 128'(1'b0));
    step(); step(); step();
    check_vec("to_owner0",   128'(bus.owner),     128'(2'd0));
    check_vec("to_trusted",  128'(bus.trusted),   128'(1'b1));
    check_vec("to_aresetn1", 128'(bus.O_aresetn), 128'(1'b1));
    drive_tx(1, 32'h0000_00A2, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_vec("to_d1_locked", 128'(bus.D_txd_tready), 128'(3'b001));
      step();
    end
    bus.D_txd_tvalid = 3'b000;

    // Reset mid-packet abandons everything
    drive_tx(0, 32'h0000_00B1, 1'b0, 1'b1);
    step();
    rstn = 1'b0;
    step();
    check_vec("rst2_o_tvld",  128'(bus.O_txd_tvalid), 128'(1'b0));
    check_vec("rst2_d_trdy",  128'(bus.D_txd_tready), 128'(3'b000));
    check_vec("rst2_trusted", 128'(bus.trusted),      128'(1'b0));
    check_vec("rst2_aresetn", 128'(bus.O_aresetn),    128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
